buf_col_sel_sequencer: RTL and testbench



---
 rtl/buf_col_pkg.sv | 13 +
 rtl/buf_col_sel_sequencer_if.sv | 26 ++
 rtl/buf_col_sel_sequencer.sv | 139 +++++++++++++
 tb/tb_buf_col_sel_sequencer.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/buf_col_pkg.sv
// Shared types and widths for the buffer column-select sequencer.
package buf_col_pkg;

  localparam int unsigned SEL_W        = 2;
  localparam int unsigned SAMPLE_IDX_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/buf_col_sel_sequencer_if.sv
// Handshake and select-register bus of the column-select sequencer.
// master: upstream/controller side; slave: the sequencer itself.
interface buf_col_sel_sequencer_if;
  import buf_col_pkg::*;

  logic                    START;
  logic                    ABORT;
  logic                    IN_VALID;
  logic                    IN_READY;
  logic [SEL_W-1:0]        SEL_DATA;
  logic                    SEL_WRITE_EN;
  logic [SAMPLE_IDX_W-1:0] SAMPLE_IDX;
  logic                    BUSY;
  logic                    DONE;

  modport master (
    output START, ABORT, IN_VALID,
    input  IN_READY, SEL_DATA, SEL_WRITE_EN, SAMPLE_IDX, BUSY, DONE
  );

  modport slave (
    input  START, ABORT, IN_VALID,
    output IN_READY, SEL_DATA, SEL_WRITE_EN, SAMPLE_IDX, BUSY, DONE
  );

endinterface

// File: rtl/buf_col_sel_sequencer.sv
// Write-side controller for the buffer column-select register.
// Counts accepted samples per column, strobes the next column select
// into the register once per column change, pulses DONE at row end.
// Optional macro BUF_COL_CONT_EN: rows run back-to-back until ABORT.
module buf_col_sel_sequencer
  import buf_col_pkg::*;
#(
  parameter int unsigned N_COLS          = 4,
  parameter int unsigned SAMPLES_PER_COL = 8
) (
  input  logic                     CLK,
  input  logic                     RST_ASYNC,
  buf_col_sel_sequencer_if.slave   bus
);

  localparam logic [SEL_W-1:0]        LAST_COL = SEL_W'(N_COLS - 1);
  localparam logic [SAMPLE_IDX_W-1:0] LAST_IDX = SAMPLE_IDX_W'(SAMPLES_PER_COL - 1);

  state_t                  state;
  logic [SEL_W-1:0]        col;
  logic [SEL_W-1:0]        sel_data;
  logic                    sel_write_en;
  logic [SAMPLE_IDX_W-1:0] sample_idx;
  logic                    busy;
  logic                    done;
  logic                    in_ready;
  logic                    beat;
  logic                    idx_last;
  logic                    col_last;

  // Ready and terminal-count decode, combinational from state/counters.
  always_comb begin
    in_ready = (state == ST_RUN);
    beat     = bus.IN_VALID & in_ready;
    idx_last = (sample_idx == LAST_IDX);
    col_last = (col == LAST_COL);
  end

  // Sample/column counters; terminal compares come first so nothing wraps.
  always_ff @(posedge CLK or posedge RST_ASYNC) begin
    if (RST_ASYNC) begin
      col        <= '0;
      sample_idx <= '0;
    end else if (bus.ABORT) begin
      col        <= '0;
      sample_idx <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.START) begin
            col        <= '0;
            sample_idx <= '0;
          end
        end
        ST_RUN: begin
          if (beat) begin
            if (!idx_last) begin
              sample_idx <= sample_idx + SAMPLE_IDX_W'(1);
            end else begin
              sample_idx <= '0;
              if (!col_last) begin
                col <= col + SEL_W'(1);
              end else begin
`ifdef BUF_COL_CONT_EN
                col <= '0;
`else
                col <= col;
`endif
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Row FSM with registered select, strobe, busy and done outputs.
  always_ff @(posedge CLK or posedge RST_ASYNC) begin
    if (RST_ASYNC) begin
      state        <= ST_IDLE;
      sel_data     <= '0;
      sel_write_en <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      sel_write_en <= 1'b0;
      done         <= 1'b0;
      if (bus.ABORT) begin
        state <= ST_IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (bus.START) begin
              state        <= ST_RUN;
              sel_data     <= '0;
              sel_write_en <= 1'b1;
              busy         <= 1'b1;
            end
          end
          ST_RUN: begin
            if (beat && idx_last) begin
              if (!col_last) begin
                sel_data     <= col + SEL_W'(1);
                sel_write_en <= 1'b1;
              end else begin
`ifdef BUF_COL_CONT_EN
                sel_data     <= '0;
                sel_write_en <= 1'b1;
                done         <= 1'b1;
`else
                state        <= ST_DONE;
                done         <= 1'b1;
`endif
              end
            end
          end
          ST_DONE: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.IN_READY     = in_ready;
  assign bus.SEL_DATA     = sel_data;
  assign bus.SEL_WRITE_EN = sel_write_en;
  assign bus.SAMPLE_IDX   = sample_idx;
  assign bus.BUSY         = busy;
  assign bus.DONE         = done;

endmodule

// File: tb/tb_buf_col_sel_sequencer.sv
// Self-checking bench for buf_col_sel_sequencer: strobe/done events are
// queued by the stimulus and compared by negedge monitors.
module tb_buf_col_sel_sequencer;
  import buf_col_pkg::*;

  logic CLK = 1'b0;
  logic RST_ASYNC;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    logic       wr;
    logic       dn;
    logic [1:0] sel;
    int         cyc;
  } ev_t;

  ev_t q1[$];
  ev_t q2[$];
  ev_t e1;
  ev_t e2;

  buf_col_sel_sequencer_if bus1();
  buf_col_sel_sequencer_if bus2();

  buf_col_sel_sequencer #(.N_COLS(4), .SAMPLES_PER_COL(8)) u_dut1 (
    .CLK(CLK), .RST_ASYNC(RST_ASYNC), .bus(bus1)
  );

  buf_col_sel_sequencer #(.N_COLS(2), .SAMPLES_PER_COL(1)) u_dut2 (
    .CLK(CLK), .RST_ASYNC(RST_ASYNC), .bus(bus2)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    #50000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic ev_t mk(input logic wr, input logic dn, input logic [1:0] sel, input int c);
    ev_t e;
    e.wr = wr; e.dn = dn; e.sel = sel; e.cyc = c;
    return e;
  endfunction

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge CLK);
  endtask

  // Monitor for the 4x8 instance.
  always @(negedge CLK) begin
    if (!RST_ASYNC && (bus1.SEL_WRITE_EN || bus1.DONE)) begin
      checks++;
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL ev1 unexpected wr=%0d done=%0d sel=%0d cyc=%0d, required no event",
                 bus1.SEL_WRITE_EN, bus1.DONE, bus1.SEL_DATA, cyc);
      end else begin
        e1 = q1.pop_front();
        if (e1.wr !== bus1.SEL_WRITE_EN || e1.dn !== bus1.DONE ||
            e1.sel !== bus1.SEL_DATA || e1.cyc != cyc) begin
          errors++;
          $display("FAIL ev1 actual wr=%0d done=%0d sel=%0d cyc=%0d required wr=%0d done=%0d sel=%0d cyc=%0d",
                   bus1.SEL_WRITE_EN, bus1.DONE, bus1.SEL_DATA, cyc, e1.wr, e1.dn, e1.sel, e1.cyc);
        end
      end
    end
  end

  // Monitor for the 2x1 instance.
  always @(negedge CLK) begin
    if (!RST_ASYNC && (bus2.SEL_WRITE_EN || bus2.DONE)) begin
      checks++;
      if (q2.size() == 0) begin
        errors++;
        $display("FAIL ev2 unexpected wr=%0d done=%0d sel=%0d cyc=%0d, required no event",
                 bus2.SEL_WRITE_EN, bus2.DONE, bus2.SEL_DATA, cyc);
      end else begin
        e2 = q2.pop_front();
        if (e2.wr !== bus2.SEL_WRITE_EN || e2.dn !== bus2.DONE ||
            e2.sel !== bus2.SEL_DATA || e2.cyc != cyc) begin
          errors++;
          $display("FAIL ev2 actual wr=%0d done=%0d sel=%0d cyc=%0d required wr=%0d done=%0d sel=%0d cyc=%0d",
                   bus2.SEL_WRITE_EN, bus2.DONE, bus2.SEL_DATA, cyc, e2.wr, e2.dn, e2.sel, e2.cyc);
        end
      end
    end
  end

  initial begin
    int s;
    RST_ASYNC     = 1'b1;
    bus1.START    = 1'b0; bus1.ABORT = 1'b0; bus1.IN_VALID = 1'b0;
    bus2.START    = 1'b0; bus2.ABORT = 1'b0; bus2.IN_VALID = 1'b0;
    repeat (2) @(negedge CLK);

    chk("rst_sel",   bus1.SEL_DATA,     0);
    chk("rst_wr",    bus1.SEL_WRITE_EN, 0);
    chk("rst_idx",   bus1.SAMPLE_IDX,   0);
    chk("rst_busy",  bus1.BUSY,         0);
    chk("rst_done",  bus1.DONE,         0);
    chk("rst_ready", bus1.IN_READY,     0);
    RST_ASYNC = 1'b0;
    @(negedge CLK);

    // Full row, continuous valid.
    s = cyc + 1;
    bus1.START = 1'b1; bus1.IN_VALID = 1'b1;
    q1.push_back(mk(1'b1, 1'b0, 2'd0, s));
    q1.push_back(mk(1'b1, 1'b0, 2'd1, s + 8));
    q1.push_back(mk(1'b1, 1'b0, 2'd2, s + 16));
    q1.push_back(mk(1'b1, 1'b0, 2'd3, s + 24));
`ifdef BUF_COL_CONT_EN
    q1.push_back(mk(1'b1, 1'b1, 2'd0, s + 32));
`else
    q1.push_back(mk(1'b0, 1'b1, 2'd3, s + 32));
`endif
    @(negedge CLK);
    bus1.START = 1'b0;
    chk("row_busy",  bus1.BUSY,       1);
    chk("row_ready", bus1.IN_READY,   1);
    chk("row_idx0",  bus1.SAMPLE_IDX, 0);
    wait_cyc(s + 12);
    chk("row_idx_mid", bus1.SAMPLE_IDX, 4);
    chk("row_sel_mid", bus1.SEL_DATA,   1);
    wait_cyc(s + 32);
`ifdef BUF_COL_CONT_EN
    chk("cont_ready", bus1.IN_READY, 1);
    bus1.ABORT = 1'b1; bus1.IN_VALID = 1'b0;
    @(negedge CLK);
    bus1.ABORT = 1'b0;
    chk("cont_abort_busy", bus1.BUSY, 0);
    chk("cont_abort_sel",  bus1.SEL_DATA, 0);
`else
    chk("done_ready", bus1.IN_READY, 0);
    chk("done_busy",  bus1.BUSY,     1);
    bus1.IN_VALID = 1'b0;
    @(negedge CLK);
    chk("idle_busy",  bus1.BUSY,     0);
    chk("idle_ready", bus1.IN_READY, 0);
    chk("idle_sel",   bus1.SEL_DATA, 3);
    chk("idle_idx",   bus1.SAMPLE_IDX, 0);
`endif

    // Toggled valid, then abort at col 2 / idx 5.
    @(negedge CLK);
    s = cyc + 1;
    bus1.START = 1'b1; bus1.IN_VALID = 1'b0;
    q1.push_back(mk(1'b1, 1'b0, 2'd0, s));
    q1.push_back(mk(1'b1, 1'b0, 2'd1, s + 15));
    q1.push_back(mk(1'b1, 1'b0, 2'd2, s + 31));
    @(negedge CLK);
    bus1.START = 1'b0; bus1.IN_VALID = 1'b1;
    while (cyc < s + 41) begin
      @(negedge CLK);
      bus1.IN_VALID = ~bus1.IN_VALID;
      if (cyc == s + 39) chk("tog_idx_beat", bus1.SAMPLE_IDX, 4);
      if (cyc == s + 40) chk("tog_idx_hold", bus1.SAMPLE_IDX, 4);
    end
    chk("tog_idx5", bus1.SAMPLE_IDX, 5);
    chk("tog_sel2", bus1.SEL_DATA,   2);
    bus1.ABORT = 1'b1;
    @(negedge CLK);
    bus1.ABORT = 1'b0;
    chk("abort_busy",  bus1.BUSY,       0);
    chk("abort_idx",   bus1.SAMPLE_IDX, 0);
    chk("abort_sel",   bus1.SEL_DATA,   2);
    chk("abort_ready", bus1.IN_READY,   0);

    // Restart after abort, START pulsed mid-row, then async reset.
    @(negedge CLK);
    s = cyc + 1;
    bus1.START = 1'b1; bus1.IN_VALID = 1'b1;
    q1.push_back(mk(1'b1, 1'b0, 2'd0, s));
    q1.push_back(mk(1'b1, 1'b0, 2'd1, s + 8));
    q1.push_back(mk(1'b1, 1'b0, 2'd2, s + 16));
    @(negedge CLK);
    bus1.START = 1'b0;
    wait_cyc(s + 10);
    bus1.START = 1'b1;
    @(negedge CLK);
    bus1.START = 1'b0;
    wait_cyc(s + 20);
    chk("restart_idx", bus1.SAMPLE_IDX, 4);
    chk("restart_sel", bus1.SEL_DATA,   2);
    #2;
    RST_ASYNC = 1'b1;
    #1;
    chk("arst_sel",  bus1.SEL_DATA,     0);
    chk("arst_busy", bus1.BUSY,         0);
    chk("arst_idx",  bus1.SAMPLE_IDX,   0);
    chk("arst_wr",   bus1.SEL_WRITE_EN, 0);
    @(negedge CLK);
    #1;
    RST_ASYNC = 1'b0;
    bus1.IN_VALID = 1'b0;

    // Next START after reset begins at column 0.
    @(negedge CLK);
    s = cyc + 1;
    bus1.START = 1'b1; bus1.IN_VALID = 1'b1;
    q1.push_back(mk(1'b1, 1'b0, 2'd0, s));
    q1.push_back(mk(1'b1, 1'b0, 2'd1, s + 8));
    @(negedge CLK);
    bus1.START = 1'b0;
    wait_cyc(s + 9);
    chk("post_rst_sel", bus1.SEL_DATA,   1);
    chk("post_rst_idx", bus1.SAMPLE_IDX, 1);
    bus1.ABORT = 1'b1; bus1.IN_VALID = 1'b0;
    @(negedge CLK);
    bus1.ABORT = 1'b0;

    // Two columns, one sample each: every beat advances the column.
    s = cyc + 1;
    bus2.START = 1'b1; bus2.IN_VALID = 1'b1;
    q2.push_back(mk(1'b1, 1'b0, 2'd0, s));
    q2.push_back(mk(1'b1, 1'b0, 2'd1, s + 1));
`ifdef BUF_COL_CONT_EN
    q2.push_back(mk(1'b1, 1'b1, 2'd0, s + 2));
    q2.push_back(mk(1'b1, 1'b0, 2'd1, s + 3));
    q2.push_back(mk(1'b1, 1'b1, 2'd0, s + 4));
`else
    q2.push_back(mk(1'b0, 1'b1, 2'd1, s + 2));
`endif
    @(negedge CLK);
    bus2.START = 1'b0;
    for (int k = 0; k < 5; k++) begin
`ifdef BUF_COL_CONT_EN
      chk("spc1_ready", bus2.IN_READY, 1);
`else
      chk("spc1_ready", bus2.IN_READY, (k < 2) ? 1 : 0);
`endif
      @(negedge CLK);
    end
    bus2.ABORT = 1'b1; bus2.IN_VALID = 1'b0;
    @(negedge CLK);
    bus2.ABORT = 1'b0;
    chk("spc1_busy_end", bus2.BUSY, 0);

    repeat (2) @(negedge CLK);
    chk("q1_drained", q1.size(), 0);
    chk("q2_drained", q2.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
